// File: rtl/board_io_pkg.sv
// board_io_pkg: shared constants and types for the board I/O conditioner.
// Optional long-press support is controlled by the BOARD_IO_LONG_PRESS_EN macro.
package board_io_pkg;

   // LED source select encodings
   typedef enum logic [1:0] {
      LED_MODE_SW     = 2'd0,
      LED_MODE_STATUS = 2'd1,
      LED_MODE_BLINK  = 2'd2,
      LED_MODE_KEYS   = 2'd3
   } led_mode_t;

   // Flip-flops in each input synchroniser chain
   localparam int SYNC_STAGES = 2;

   // Larger of two integers; used to size zero-extension vectors
   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/board_io_if.sv
// board_io_if: board-side pins and conditioned outputs of board_io_ctrl.
// master = system/bench side, slave = board_io_ctrl.
// key_long exists only when BOARD_IO_LONG_PRESS_EN is defined.
interface board_io_if #(
   parameter int N_KEYS = 4,
   parameter int N_SW   = 10,
   parameter int N_LEDS = 10
);
   // Raw board inputs and system-side controls
   logic [N_KEYS-1:0] key_n;
   logic [N_SW-1:0]   sw;
   logic [1:0]        led_mode;
   logic [N_LEDS-1:0] led_status;

   // Conditioned outputs
   logic [N_KEYS-1:0] key_down;
   logic [N_KEYS-1:0] key_press;
   logic [N_KEYS-1:0] key_release;
   logic [N_SW-1:0]   sw_q;
   logic              sys_reset_req;
   logic              heartbeat;
   logic [N_LEDS-1:0] ledr;
`ifdef BOARD_IO_LONG_PRESS_EN
   logic [N_KEYS-1:0] key_long;

   modport master (
      output key_n, sw, led_mode, led_status,
      input  key_down, key_press, key_release, sw_q,
             sys_reset_req, heartbeat, ledr, key_long
   );

   modport slave (
      input  key_n, sw, led_mode, led_status,
      output key_down, key_press, key_release, sw_q,
             sys_reset_req, heartbeat, ledr, key_long
   );
`else
   modport master (
      output key_n, sw, led_mode, led_status,
      input  key_down, key_press, key_release, sw_q,
             sys_reset_req, heartbeat, ledr
   );

   modport slave (
      input  key_n, sw, led_mode, led_status,
      output key_down, key_press, key_release, sw_q,
             sys_reset_req, heartbeat, ledr
   );
`endif
endinterface

// File: rtl/board_io_debounce.sv
// io_debounce: one input channel -- synchroniser, stability counter,
// accepted level and registered rise/fall pulses. din_i is already in
// active-high form; RESET_LEVEL is the idle level loaded by reset.
module io_debounce
   import board_io_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = 500000,
   parameter logic RESET_LEVEL     = 1'b0
) (
   input  logic clk,
   input  logic reset_n,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   stable_prev_q;
   logic                   rise_q, fall_q;
   logic                   sync_bit;

   assign sync_bit = sync_q[SYNC_STAGES-1];

   // Shift the synchroniser; count while the synced level disagrees with
   // the accepted one, accept it after DEBOUNCE_CYCLES mismatching cycles
   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], din_i};
      cnt_d    = '0;
      stable_d = stable_q;
      if (sync_bit != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = sync_bit;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Channel state registers and one-cycle edge pulses
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_q        <= {SYNC_STAGES{RESET_LEVEL}};
         cnt_q         <= '0;
         stable_q      <= RESET_LEVEL;
         stable_prev_q <= RESET_LEVEL;
         rise_q        <= 1'b0;
         fall_q        <= 1'b0;
      end else begin
         sync_q        <= sync_d;
         cnt_q         <= cnt_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         rise_q        <= stable_q & ~stable_prev_q;
         fall_q        <= ~stable_q & stable_prev_q;
      end
   end

   assign level_o = stable_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/board_io_ctrl.sv
// board_io_ctrl: DE1-SoC key/switch conditioner, KEY[0] reset request
// stretcher, heartbeat and registered LED mux.
// Define BOARD_IO_LONG_PRESS_EN to add per-key long-press pulses (key_long).
module board_io_ctrl
   import board_io_pkg::*;
#(
   parameter int N_KEYS            = 4,
   parameter int N_SW              = 10,
   parameter int N_LEDS            = 10,
   parameter int DEBOUNCE_CYCLES   = 500000,
   parameter int RESET_STRETCH     = 1024,
   parameter int BLINK_DIV         = 25000000,
   parameter int LONG_PRESS_CYCLES = 50000000
) (
   input logic        clk,
   input logic        reset_n,
   board_io_if.slave  io
);

   localparam int             STW          = $clog2(RESET_STRETCH + 1);
   localparam logic [STW-1:0] STRETCH_LOAD = STW'(RESET_STRETCH - 1);
   localparam int             BW           = $clog2(BLINK_DIV + 1);
   localparam logic [BW-1:0]  BLINK_LAST   = BW'(BLINK_DIV - 1);
   localparam int             SW_EXT_W     = max_int(N_SW, N_LEDS);
   localparam int             KEY_EXT_W    = max_int(N_KEYS, N_LEDS - 1);

   logic [N_KEYS-1:0] key_down_w, key_press_w, key_release_w;
   logic [N_SW-1:0]   sw_level_w;
   logic [N_SW-1:0]   sw_rise_unused, sw_fall_unused;

   // Key channels: buttons are active-low, so invert before debouncing
   for (genvar g = 0; g < N_KEYS; g++) begin : g_key
      io_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (1'b0)
      ) u_key (
         .clk     (clk),
         .reset_n (reset_n),
         .din_i   (~io.key_n[g]),
         .level_o (key_down_w[g]),
         .rise_o  (key_press_w[g]),
         .fall_o  (key_release_w[g])
      );
   end

   // Switch channels: only the debounced level is used
   for (genvar g = 0; g < N_SW; g++) begin : g_sw
      io_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (1'b0)
      ) u_sw (
         .clk     (clk),
         .reset_n (reset_n),
         .din_i   (io.sw[g]),
         .level_o (sw_level_w[g]),
         .rise_o  (sw_rise_unused[g]),
         .fall_o  (sw_fall_unused[g])
      );
   end

   // ---------------------------------------------------------------------
   // Reset request: KEY[0] level OR'd with a stretch counter loaded on press
   // ---------------------------------------------------------------------
   logic [STW-1:0] stretch_q, stretch_d;
   logic           req_q, req_d;

   // Reload on every KEY[0] press, otherwise count down and hold at zero
   always_comb begin
      stretch_d = stretch_q;
      if (key_press_w[0]) begin
         stretch_d = STRETCH_LOAD;
      end else if (stretch_q != '0) begin
         stretch_d = stretch_q - STW'(1);
      end
      req_d = key_down_w[0] | (stretch_q != '0);
   end

   // Stretch counter and registered request
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stretch_q <= '0;
         req_q     <= 1'b0;
      end else begin
         stretch_q <= stretch_d;
         req_q     <= req_d;
      end
   end

   // ---------------------------------------------------------------------
   // Heartbeat: toggle every BLINK_DIV cycles
   // ---------------------------------------------------------------------
   logic [BW-1:0] blink_q, blink_d;
   logic          hb_q, hb_d;

   // Free-running divider with wrap-and-toggle
   always_comb begin
      blink_d = blink_q + BW'(1);
      hb_d    = hb_q;
      if (blink_q == BLINK_LAST) begin
         blink_d = '0;
         hb_d    = ~hb_q;
      end
   end

   // Divider and heartbeat registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         blink_q <= '0;
         hb_q    <= 1'b0;
      end else begin
         blink_q <= blink_d;
         hb_q    <= hb_d;
      end
   end

   // ---------------------------------------------------------------------
   // LED mux: one registered stage, mode sampled every cycle
   // ---------------------------------------------------------------------
   led_mode_t             mode_w;
   logic [SW_EXT_W-1:0]   sw_ext;
   logic [KEY_EXT_W-1:0]  key_ext;
   logic [N_LEDS-1:0]     ledr_q, ledr_d;

   assign mode_w  = led_mode_t'(io.led_mode);
   assign sw_ext  = SW_EXT_W'(sw_level_w);
   assign key_ext = KEY_EXT_W'(key_down_w);

   // Select the LED source for the next cycle
   always_comb begin
      ledr_d = '0;
      case (mode_w)
         LED_MODE_SW:     ledr_d = sw_ext[N_LEDS-1:0];
         LED_MODE_STATUS: ledr_d = io.led_status;
         LED_MODE_BLINK:  ledr_d = io.led_status & {N_LEDS{hb_q}};
         LED_MODE_KEYS:   ledr_d = {hb_q, key_ext[N_LEDS-2:0]};
         default:         ledr_d = '0;
      endcase
   end

   // LED output register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ledr_q <= '0;
      end else begin
         ledr_q <= ledr_d;
      end
   end

`ifdef BOARD_IO_LONG_PRESS_EN
   // ---------------------------------------------------------------------
   // Long press: per-key saturating hold counter, one pulse per hold
   // ---------------------------------------------------------------------
   localparam int            LW        = $clog2(LONG_PRESS_CYCLES + 1);
   localparam logic [LW-1:0] HOLD_LAST = LW'(LONG_PRESS_CYCLES - 1);

   logic [LW-1:0]     hold_q [N_KEYS];
   logic [LW-1:0]     hold_d [N_KEYS];
   logic [N_KEYS-1:0] reached_q, reached_d;
   logic [N_KEYS-1:0] key_long_q, key_long_d;

   // Count while held, clear on release; pulse on first cycle at the limit
   always_comb begin
      for (int k = 0; k < N_KEYS; k++) begin
         hold_d[k] = '0;
         if (key_down_w[k]) begin
            hold_d[k] = (hold_q[k] == HOLD_LAST) ? hold_q[k] : hold_q[k] + LW'(1);
         end
         reached_d[k]  = key_down_w[k] && (hold_q[k] == HOLD_LAST);
         key_long_d[k] = reached_d[k] & ~reached_q[k];
      end
   end

   // Hold counters and pulse registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int k = 0; k < N_KEYS; k++) begin
            hold_q[k] <= '0;
         end
         reached_q  <= '0;
         key_long_q <= '0;
      end else begin
         for (int k = 0; k < N_KEYS; k++) begin
            hold_q[k] <= hold_d[k];
         end
         reached_q  <= reached_d;
         key_long_q <= key_long_d;
      end
   end

   assign io.key_long = key_long_q;
`else
   // No long-press hardware in this build
   localparam int LONG_PRESS_UNUSED = LONG_PRESS_CYCLES;
`endif

   assign io.key_down      = key_down_w;
   assign io.key_press     = key_press_w;
   assign io.key_release   = key_release_w;
   assign io.sw_q          = sw_level_w;
   assign io.sys_reset_req = req_q;
   assign io.heartbeat     = hb_q;
   assign io.ledr          = ledr_q;

endmodule

// File: doc/board_io_ctrl.md
Name: board_io_ctrl

Overview:
Parametrised board I/O conditioner for the DE1-SoC top level, replacing direct pin-to-pin wiring of KEY, SW and LEDR. Synchronises and debounces N_KEYS active-low push-buttons and N_SW slide switches, and emits per-key press/release pulses. Generates a stretched system reset request from KEY[0]. Drives LEDR through a registered, mode-selectable LED mux with a heartbeat.

Parameters:
N_KEYS, 4, number of push-buttons (1..8)
N_SW, 10, number of slide switches (1..16)
N_LEDS, 10, number of LEDs (2..16)
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a change (>=1; 10 ms @ 50 MHz)
RESET_STRETCH, 1024, minimum sys_reset_req length in cycles after a KEY[0] press (>=1)
BLINK_DIV, 25000000, heartbeat half-period in cycles (>=1)
LONG_PRESS_CYCLES, 50000000, hold time for the long-press pulse (optional feature only)

Ports:
clk  in  1  system clock (CLOCK_50 domain)
reset_n  in  1  synchronous reset, active-low
key_n  in  N_KEYS  raw push-buttons, active-low, asynchronous
sw  in  N_SW  raw slide switches, asynchronous
led_mode  in  2  LED source select, synchronous to clk
led_status  in  N_LEDS  status word from the system
key_down  out  N_KEYS  debounced key state, 1 = pressed
key_press  out  N_KEYS  one-cycle pulse on a debounced press
key_release  out  N_KEYS  one-cycle pulse on a debounced release
sw_q  out  N_SW  debounced switch levels
sys_reset_req  out  1  active-high reset request derived from KEY[0]
heartbeat  out  1  square wave, period 2*BLINK_DIV cycles
ledr  out  N_LEDS  registered LED drive

Behaviour:
- Reset is synchronous, active-low, one clock. Inside reset: all synchroniser FFs go to their inactive level (key = released, sw = 0), debounce counters = 0, key_down = 0, sw_q = 0, key_press = key_release = 0, sys_reset_req = 0, stretch counter = 0, heartbeat = 0, blink counter = 0, ledr = 0.
- Synchroniser: 2 FFs per input. key_n is inverted before debouncing.
- Debounce (per channel, independent): the counter increments while sync != stable and clears whenever sync == stable. At an edge with counter == DEBOUNCE_CYCLES-1 and sync still != stable: stable <= sync and counter <= 0. Latency: a raw change held steady appears on key_down/sw_q DEBOUNCE_CYCLES+2 edges after the first sampling edge. A glitch shorter than DEBOUNCE_CYCLES cycles produces no change. Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Pulses: key_press = stable & ~stable_d and key_release = ~stable & stable_d, both registered, asserted for exactly one cycle on the cycle after stable changes. Simultaneous events on different keys are independent.
- Reset request: on a KEY[0] key_press the stretch counter loads RESET_STRETCH-1. The counter decrements to 0 and saturates. sys_reset_req = key_down[0] | (counter != 0), registered. It is therefore high for at least RESET_STRETCH cycles, and for as long as KEY[0] is held. A re-press during stretch reloads the counter.
- Heartbeat: the blink counter counts 0..BLINK_DIV-1. On wrap, heartbeat toggles.
- LED mux, registered, one cycle latency; led_mode is sampled each cycle, no debounce:
  - 0: sw_q, zero-extended or truncated to N_LEDS.
  - 1: led_status.
  - 2: led_status & {N_LEDS{heartbeat}}.
  - 3: ledr[N_LEDS-1] = heartbeat; key_down occupies the low bits; all other bits 0.
- Reset asserted mid-debounce or mid-stretch aborts the operation. Debounce restarts from the reset state.

Optional Feature:
BOARD_IO_LONG_PRESS_EN:
- Defined: adds output key_long [N_KEYS], plus a per-key hold counter that runs while key_down is 1 and clears on release or reset.
- key_long pulses for one cycle when the hold counter reaches LONG_PRESS_CYCLES-1. The pulse fires once per hold; the counter saturates.
- Undefined: no port, no counters; all other behaviour is identical.

Decomposition:
- Package board_io_pkg holds:
  - LED mode constants: LED_MODE_SW=0, LED_MODE_STATUS=1, LED_MODE_BLINK=2, LED_MODE_KEYS=3.
  - A 2-bit led_mode_t typedef.
  - The synchroniser depth constant SYNC_STAGES=2.
- Sub-module io_debounce: one channel (sync + counter + stable reg + edge pulses), parameter DEBOUNCE_CYCLES and RESET_LEVEL. It is instantiated N_KEYS+N_SW times via generate.

Test Plan:
(Bench parameters: DEBOUNCE_CYCLES=4, RESET_STRETCH=8, BLINK_DIV=5, LONG_PRESS_CYCLES=10.)
- key_n[1] 1->0 held -> key_down[1]=1 exactly 6 edges later; key_press[1] high for one cycle on the next cycle; key_release stays 0.
- key_n[2] low for 3 cycles then high -> key_down[2] and key_press[2] never assert; a low for 4 cycles with bounce at cycle 2 also -> no change.
- key_n[0] press held 2 cycles past debounce, then released -> sys_reset_req high for exactly 8 cycles from the press pulse. Held 20 cycles -> high until the debounced release.
- led_mode=0 with sw=10'h2A5 stable -> ledr=10'h2A5 one cycle after sw_q settles. led_mode=2, led_status=10'h3FF -> ledr alternates 0/3FF every 5 cycles.
- reset_n low for 1 cycle mid-debounce (counter=2) -> all outputs 0 next cycle, and debounce restarts with full 6-edge latency.
- With BOARD_IO_LONG_PRESS_EN: key held 30 cycles -> exactly one key_long pulse, 10 cycles after key_down rises; without the macro the bench compiles without key_long.
